md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//   Multiply/divide sequencer for the HI/LO resource of the pipelined MIPS core.
//   - Sits beside the E stage: accepts mult/multu/div/divu/mthi/mtlo from E and owns the architectural HI/LO registers.
//   - Models fixed multi-cycle latency with a busy window.
//   - Raises a stall toward D while any D-stage HI/LO user would collide with an in-flight operation.
//   - HI/LO outputs feed the E->M pipeline register for mfhi/mflo.
// PARAMETERS
//   W            32   operand / HI / LO width
//   MULT_CYCLES  5    busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10   busy cycles for div/divu (>=1)
// PORTS
//   clk        in   1    rising-edge clock
//   reset      in   1    asynchronous, active-high; clears all state
//   start      in   1    E-stage instruction is an md op; qualifies md_op
//   md_op      in   3    1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 0/7 = no-op
//   A          in   W    forwarded rs value from E
//   B          in   W    forwarded rt value from E
//   md_use_D   in   1    D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
//   busy       out  1    operation in flight
//   HI         out  W    architectural HI
//   LO         out  W    architectural LO
//   stall      out  1    freeze PC/F/D and bubble E: = md_use_D & (busy | (start & md_op in 1..4))
// BEHAVIOUR
//   Reset values
//     - Async on reset rise: HI=0, LO=0, busy=0, state=IDLE, count=0, pending result regs=0.
//     - Outputs hold 0 while reset is high.
//   States
//     - IDLE: start & op 1..4 at edge t captures A, B and op; goes to MUL/DIV with count=N-1.
//       N = MULT_CYCLES or DIV_CYCLES.
//     - MUL/DIV: count decrements each edge. At the edge where count==0: HI/LO <= result, busy<=0, state<=IDLE.
//   Timing
//     - busy is high for exactly N cycles following the start cycle.
//     - HI/LO change at the edge ending the last busy cycle.
//     - A D-stage mfhi stalled by busy sees the new HI on the first non-stalled cycle.
//   mthi/mtlo
//     - Single-cycle, accepted in IDLE only.
//     - HI<=A (mthi) or LO<=A (mtlo) at the next edge. busy stays 0.
//   start while busy: ignored, no state change. The stall rule prevents this in a correct pipeline.
//   start with md_op 0 or 7: ignored.
//   Arithmetic
//     - mult: {HI,LO} = signed A*B, 2W bits.
//     - multu: {HI,LO} = unsigned A*B, 2W bits.
//     - div/divu: LO = quotient, HI = remainder.
//     - Signed division truncates toward zero; remainder takes the sign of the dividend.
//     - div of -2^(W-1) by -1: LO=0x80000000, HI=0.
//     - B==0 (div/divu): full DIV_CYCLES busy window; HI/LO unchanged at completion.
//   Result latching
//     - Result is computed from the operands captured at start.
//     - A/B changing during busy has no effect.
//   Reset mid-operation: the operation is abandoned; HI/LO=0, no late write-back after reset falls.
// TESTING
//   1. reset pulse mid-cycle (async) -> HI=LO=0, busy=0 immediately. mthi A=0x12345678 -> HI=0x12345678 next edge, busy stays 0.
//   2. mult A=0xFFFFFFFF(-1) B=2 -> busy high 5 cycles.
//      - HI=0xFFFFFFFF, LO=0xFFFFFFFE after the 5th busy cycle.
//      - multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
//   3. div A=-7(0xFFFFFFF9) B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//      - divu A=7 B=2 -> LO=3, HI=1.
//   4. div A=5 B=0 with HI=0xAA, LO=0xBB -> busy 10 cycles; HI=0xAA, LO=0xBB unchanged.
//      - div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//   5. Stall and ignored start.
//      - start mult with md_use_D=1 -> stall=1 in the start cycle and all 5 busy cycles, 0 after.
//      - md_use_D=0 during busy -> stall=0.
//      - start asserted during busy -> ignored; HI/LO and count unaffected.
//   6. reset asserted at busy cycle 3 of a div -> busy=0, HI=LO=0 at once; no HI/LO update within 20 cycles after release.

Source files
------------

// File: rtl/md_sequencer_if.sv
// HI/LO sequencer handshake bundle between the E/D stages (master) and md_sequencer (slave).
// Carries the md op request, the forwarded operands, the D-stage use flag and the HI/LO/busy/stall results.
interface md_sequencer_if #(
  parameter int W = 32
);
  logic         start;
  logic [2:0]   md_op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         md_use_D;
  logic         busy;
  logic [W-1:0] HI;
  logic [W-1:0] LO;
  logic         stall;

  modport master (
    output start, md_op, A, B, md_use_D,
    input  busy, HI, LO, stall
  );

  modport slave (
    input  start, md_op, A, B, md_use_D,
    output busy, HI, LO, stall
  );
endinterface

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer owning HI/LO: mult/div hold busy for a fixed N cycles, then write HI/LO.
// mthi/mtlo write in one cycle; stall toward D is combinational while a D-stage HI/LO user would collide.
module md_sequencer #(
  parameter int W           = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  md_sequencer_if.slave  md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;

  logic          long_start;
  logic [2*W-1:0] prod_u;
  logic [2*W-1:0] prod_s;
  logic [2*W-1:0] prod;
  logic          a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag, b_safe;
  logic [W-1:0]  q_mag, r_mag;
  logic [W-1:0]  quo, rem;

  assign long_start = md.start & (md.md_op >= OP_MULT) & (md.md_op <= OP_DIVU);

  // Arithmetic works only on the operands captured at start, so E-stage forwarding changes are invisible.
  always_comb begin
    prod_u = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    prod_s = {{W{a_q[W-1]}}, a_q} * {{W{b_q[W-1]}}, b_q};
    prod   = (op_q == OP_MULT) ? prod_s : prod_u;
  end

  // Sign-magnitude division: truncates toward zero, remainder follows the dividend.
  // The most-negative / -1 case falls out naturally as an unsigned magnitude of 2^(W-1).
  always_comb begin
    a_neg  = (op_q == OP_DIV) & a_q[W-1];
    b_neg  = (op_q == OP_DIV) & b_q[W-1];
    a_mag  = a_neg ? (-a_q) : a_q;
    b_mag  = b_neg ? (-b_q) : b_q;
    b_safe = (b_mag == '0) ? W'(1) : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? (-q_mag) : q_mag;
    rem    = a_neg ? (-r_mag) : r_mag;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (md.start) begin
          unique case (md.md_op)
            OP_MULT, OP_MULTU: begin
              state_d = S_MUL;
              count_d = MULT_LOAD;
              op_d    = md.md_op;
              a_d     = md.A;
              b_d     = md.B;
            end
            OP_DIV, OP_DIVU: begin
              state_d = S_DIV;
              count_d = DIV_LOAD;
              op_d    = md.md_op;
              a_d     = md.A;
              b_d     = md.B;
            end
            OP_MTHI: hi_d = md.A;
            OP_MTLO: lo_d = md.A;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (count_q == '0) begin
          hi_d    = prod[2*W-1:W];
          lo_d    = prod[W-1:0];
          state_d = S_IDLE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      S_DIV: begin
        if (count_q == '0) begin
          // Divide by zero still burns the full window but leaves HI/LO untouched.
          if (b_q != '0) begin
            hi_d = rem;
            lo_d = quo;
          end
          state_d = S_IDLE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.busy  = (state_q != S_IDLE);
  assign md.HI    = hi_q;
  assign md.LO    = lo_q;
  assign md.stall = ~reset & md.md_use_D & (md.busy | long_start);

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: stimulus queues expected HI/LO and busy length, a negedge monitor checks completions.
module tb_md_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  md_sequencer_if #(.W(32)) mif();

  md_sequencer #(.W(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Completion monitor: a busy 1->0 fall outside reset pops one expectation.
  bit prev_busy = 1'b0;
  int busy_len  = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_busy = 1'b0;
      busy_len  = 0;
    end else begin
      if (mif.busy) begin
        busy_len++;
      end else if (prev_busy) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: HI=%h LO=%h with no op outstanding", mif.HI, mif.LO);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_hi"}, mif.HI, e.hi);
          check({e.name, "_lo"}, mif.LO, e.lo);
          check({e.name, "_busylen"}, busy_len, e.len);
        end
        busy_len = 0;
      end
      prev_busy = mif.busy;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic use_d);
    @(posedge clk); #1;
    mif.start    = 1'b1;
    mif.md_op    = op;
    mif.A        = a;
    mif.B        = b;
    mif.md_use_D = use_d;
    @(posedge clk); #1;
    mif.start    = 1'b0;
    mif.md_op    = 3'd0;
    mif.md_use_D = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!mif.busy && sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: busy=%b pending=%0d, required idle", name, mif.busy, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run_long(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                          input int len);
    exp_t e;
    e.name = name; e.hi = hi; e.lo = lo; e.len = len;
    sb_q.push_back(e);
    issue(op, a, b, 1'b0);
    wait_idle(name);
  endtask

  task automatic move_to(input string name, input logic [2:0] op, input logic [31:0] a);
    issue(op, a, 32'h0, 1'b0);
    if (op == 3'd5) check({name, "_hi"}, mif.HI, a);
    else            check({name, "_lo"}, mif.LO, a);
    check({name, "_busy"}, {31'b0, mif.busy}, 32'h0);
  endtask

  initial begin
    exp_t e;
    bit   late;
    mif.start    = 1'b0;
    mif.md_op    = 3'd0;
    mif.A        = 32'h0;
    mif.B        = 32'h0;
    mif.md_use_D = 1'b0;

    #2;
    check("rst_hi", mif.HI, 32'h0);
    check("rst_lo", mif.LO, 32'h0);
    check("rst_busy", {31'b0, mif.busy}, 32'h0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;

    move_to("mthi_pre", 3'd5, 32'hCAFEF00D);
    move_to("mtlo_pre", 3'd6, 32'h0BADF00D);

    // Asynchronous reset pulse in the middle of a cycle
    @(posedge clk); #3 reset = 1'b1;
    #1;
    check("pulse_hi", mif.HI, 32'h0);
    check("pulse_lo", mif.LO, 32'h0);
    check("pulse_busy", {31'b0, mif.busy}, 32'h0);
    @(posedge clk); #3 reset = 1'b0;

    move_to("mthi", 3'd5, 32'h12345678);

    run_long("mult_m1x2",   3'd1, 32'hFFFFFFFF, 32'h2,     32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    run_long("multu_m1x2",  3'd2, 32'hFFFFFFFF, 32'h2,     32'h00000001, 32'hFFFFFFFE, 5);
    run_long("multu_2p32",  3'd2, 32'h00010000, 32'h10000, 32'h00000001, 32'h00000000, 5);
    run_long("div_m7_2",    3'd3, 32'hFFFFFFF9, 32'h2,     32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_long("divu_7_2",    3'd4, 32'h7,        32'h2,     32'h00000001, 32'h00000003, 10);

    move_to("mthi_aa", 3'd5, 32'hAA);
    move_to("mtlo_bb", 3'd6, 32'hBB);
    run_long("div_by0",     3'd3, 32'h5,        32'h0,     32'h000000AA, 32'h000000BB, 10);
    run_long("div_ovf",     3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);

    // Stall through the start cycle and all five busy cycles
    e.name = "mult_stall"; e.hi = 32'h0; e.lo = 32'd12; e.len = 5;
    sb_q.push_back(e);
    @(posedge clk); #1;
    mif.start = 1'b1; mif.md_op = 3'd1; mif.A = 32'd3; mif.B = 32'd4; mif.md_use_D = 1'b1;
    #2 check("stall_start", {31'b0, mif.stall}, 32'h1);
    @(posedge clk); #1;
    mif.start = 1'b0; mif.md_op = 3'd0;
    for (int i = 0; i < 5; i++) begin
      #2 check($sformatf("stall_busy%0d", i + 1), {31'b0, mif.stall}, 32'h1);
      @(posedge clk); #1;
    end
    #2 check("stall_after", {31'b0, mif.stall}, 32'h0);
    mif.md_use_D = 1'b0;
    wait_idle("mult_stall");

    // No D-stage user during busy, plus a start that must be ignored
    e.name = "mult_ign"; e.hi = 32'h0; e.lo = 32'd42; e.len = 5;
    sb_q.push_back(e);
    issue(3'd1, 32'd6, 32'd7, 1'b0);
    #2 check("nostall_busy", {31'b0, mif.stall}, 32'h0);
    @(posedge clk); #1;
    mif.start = 1'b1; mif.md_op = 3'd3; mif.A = 32'd100; mif.B = 32'd3;
    #2 check("nostall_ign", {31'b0, mif.stall}, 32'h0);
    @(posedge clk); #1;
    mif.start = 1'b0; mif.md_op = 3'd0;
    wait_idle("mult_ign");

    // Reset during busy cycle 3 of a div abandons it
    move_to("mthi_55", 3'd5, 32'h55);
    issue(3'd3, 32'd100, 32'd7, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, mif.busy}, 32'h0);
    check("abort_hi", mif.HI, 32'h0);
    check("abort_lo", mif.LO, 32'h0);
    @(posedge clk); #3 reset = 1'b0;
    late = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (mif.HI !== 32'h0 || mif.LO !== 32'h0 || mif.busy !== 1'b0) late = 1'b1;
    end
    check("no_late_wb", {31'b0, late}, 32'h0);
    check("sb_drained", sb_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
